// File: rtl/mem_burst_ctrl.sv
// Cache-line burst sequencer: splits one line request into BEATS req/ack memory beats.
// Define MEM_TIMEOUT_EN to abort a line when a beat waits TIMEOUT cycles for mem_ack.
module mem_burst_ctrl #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int BEATS   = 8,
   parameter int TIMEOUT = 256
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic                     req_src,
   input  logic [ADDR_W-1:0]        req_addr,
   output logic [$clog2(BEATS)-1:0] beat_idx,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     wr_data_ack,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   output logic                     rd_last,
   output logic                     rsp_src,
   output logic                     done,
   output logic                     error,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic                     mem_ack,
   input  logic [DATA_W-1:0]        mem_rdata
);

   localparam int BYTES  = DATA_W / 8;
   localparam int OFF_W  = $clog2(BYTES);
   localparam int IDX_W  = $clog2(BEATS);
   localparam int LINE_W = $clog2(BEATS * BYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << LINE_W) - ADDR_W'(1));

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   if (BEATS < 2 || TIMEOUT < 2) begin : g_param_check
      $error("mem_burst_ctrl: BEATS and TIMEOUT must both be at least 2");
   end

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [ADDR_W-1:0] base;
   logic              beat_ack;
   logic              last_beat;
   logic              timed_out;

   assign req_ready   = (state == S_IDLE);
   assign mem_req     = (state == S_READ) || (state == S_WRITE);
   assign mem_we      = (state == S_WRITE);
   assign done        = (state == S_DONE);
   assign mem_wdata   = wr_data;
   assign wr_data_ack = (state == S_WRITE) && mem_ack;
   assign mem_addr    = mem_req ? base + (ADDR_W'(beat_idx) << OFF_W) : '0;
   // Acks outside READ/WRITE never reach the beat logic.
   assign beat_ack    = mem_req && mem_ack;
   assign last_beat   = (beat_idx == IDX_W'(BEATS - 1));

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT);
   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   // Idle cycles hold the counter at zero, so acceptance starts every line fresh.
   always_ff @(posedge clk) begin
      if (reset || !mem_req || mem_ack) wait_cnt <= '0;
      else                              wait_cnt <= wait_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset || state == S_IDLE) err_q <= 1'b0;
      else if (timed_out)           err_q <= 1'b1;
   end

   assign timed_out = mem_req && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));
   assign error     = done && err_q;
`else
   assign timed_out = 1'b0;
   assign error     = 1'b0;
`endif

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         S_IDLE:          if (req_valid) state_nxt = req_write ? S_WRITE : S_READ;
         S_READ, S_WRITE: if (timed_out || (mem_ack && last_beat)) state_nxt = S_DONE;
         S_DONE:          state_nxt = S_IDLE;
         default:         state_nxt = S_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         base     <= '0;
         beat_idx <= '0;
         rsp_src  <= 1'b0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         state    <= state_nxt;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         if (state == S_IDLE && req_valid) begin
            base     <= req_addr & ALIGN_MASK;
            rsp_src  <= req_src;
            beat_idx <= '0;
         end
         if (beat_ack) begin
            beat_idx <= beat_idx + 1'b1;
            if (state == S_READ) begin
               rd_data  <= mem_rdata;
               rd_valid <= 1'b1;
               rd_last  <= last_beat;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: table of line bursts plus hand-written corner sequences.
// Read beats are scoreboarded: expectations are queued at each ack and popped on rd_valid.
module tb_mem_burst_ctrl;

   localparam int ADDR_W  = 64;
   localparam int DATA_W  = 64;
   localparam int BEATS   = 8;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic              req_src;
   logic [ADDR_W-1:0] req_addr;
   logic [2:0]        beat_idx;
   logic [DATA_W-1:0] wr_data;
   logic              wr_data_ack;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_last;
   logic              rsp_src;
   logic              done;
   logic              error;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   typedef struct {
      logic [63:0] addr;
      logic        write;
      logic        src;
      logic [63:0] exp_base;
      int          stall;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic        last;
   } rd_exp_t;

   vec_t    vecs[5];
   rd_exp_t rd_q[$];
   int      checks   = 0;
   int      errors   = 0;
   int      burst_no = 0;

   always #5 clk = ~clk;

   mem_burst_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_src(req_src), .req_addr(req_addr), .beat_idx(beat_idx),
      .wr_data(wr_data), .wr_data_ack(wr_data_ack),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
      .rsp_src(rsp_src), .done(done), .error(error),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Read scoreboard: every rd_valid must match the oldest queued beat.
   always @(negedge clk) begin
      rd_exp_t e;
      if (rd_valid) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got rd_data 0x%0h, expected no read beat", rd_data);
         end else begin
            e = rd_q.pop_front();
            check("rd_data", rd_data, e.data);
            check("rd_last", 64'(rd_last), 64'(e.last));
         end
      end else if (rd_last) begin
         check("rd_last_without_valid", 64'(rd_last), 64'd0);
      end
   end

   // Runs the beats of an accepted line, starting in the first cycle after acceptance.
   task automatic finish_burst(input logic wr, input logic src, input logic [63:0] base,
                               input int stall, input bit busy);
      int   beat    = 0;
      int   cyc     = 0;
      int   wr_acks = 0;
      logic ack;
      burst_no++;
      while (beat < BEATS && cyc < 200) begin
         ack       = (stall == 0) || (cyc % stall == stall - 1);
         mem_ack   = ack;
         mem_rdata = {16'hBEEF, 16'(burst_no), 32'(beat)};
         wr_data   = {16'hC0DE, 16'(burst_no), 32'(beat)};
         if (busy) begin
            if (cyc == 1) begin
               req_valid = 1'b1; req_addr = 64'h9999; req_src = ~src; req_write = 1'b1;
            end else if (cyc == 2) begin
               req_valid = 1'b0;
            end else if (cyc >= 4) begin
               req_valid = 1'b1; req_addr = 64'h5678; req_src = 1'b0; req_write = 1'b1;
            end
         end
         #1;
         check("mem_req", 64'(mem_req), 64'd1);
         check("mem_we", 64'(mem_we), 64'(wr));
         check("mem_addr", mem_addr, base + 64'(beat) * 64'd8);
         check("beat_idx", 64'(beat_idx), 64'(beat));
         check("req_ready_busy", 64'(req_ready), 64'd0);
         check("done_busy", 64'(done), 64'd0);
         check("rsp_src_busy", 64'(rsp_src), 64'(src));
         if (wr) begin
            check("mem_wdata", mem_wdata, wr_data);
            check("wr_data_ack", 64'(wr_data_ack), 64'(ack));
         end else begin
            check("wr_data_ack_read", 64'(wr_data_ack), 64'd0);
         end
         if (wr_data_ack) wr_acks++;
         if (ack) begin
            if (!wr) rd_q.push_back('{data: mem_rdata, last: (beat == BEATS - 1)});
            beat++;
         end
         step();
         cyc++;
      end
      if (beat < BEATS) begin
         checks++;
         errors++;
         $display("FAIL burst_budget: got %0d beats, expected %0d", beat, BEATS);
      end
      mem_ack = 1'b0;
      #1;
      check("done_pulse", 64'(done), 64'd1);
      check("error_clean", 64'(error), 64'd0);
      check("rsp_src_done", 64'(rsp_src), 64'(src));
      check("mem_req_done", 64'(mem_req), 64'd0);
      check("req_ready_done", 64'(req_ready), 64'd0);
      check("wr_data_ack_done", 64'(wr_data_ack), 64'd0);
      check("rd_valid_with_done", 64'(rd_valid), 64'(!wr));
      check("rd_last_with_done", 64'(rd_last), 64'(!wr));
      if (wr) check("wr_ack_count", 64'(wr_acks), 64'(BEATS));
      step();
      #1;
      check("done_one_cycle", 64'(done), 64'd0);
      check("req_ready_back", 64'(req_ready), 64'd1);
   endtask

   task automatic run_burst(input vec_t v);
      req_valid = 1'b1;
      req_addr  = v.addr;
      req_write = v.write;
      req_src   = v.src;
      mem_ack   = 1'b0;
      #1;
      check("req_ready_idle", 64'(req_ready), 64'd1);
      step();
      req_valid = 1'b0;
      finish_burst(v.write, v.src, v.exp_base, v.stall, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{64'h1234, 1'b0, 1'b1, 64'h1200, 0};
      vecs[1] = '{64'h1234, 1'b1, 1'b0, 64'h1200, 3};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 0};
      vecs[3] = '{64'h7F, 1'b1, 1'b1, 64'h40, 0};
      vecs[4] = '{64'h40, 1'b0, 1'b0, 64'h40, 2};

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_src = 1'b0;
      req_addr = '0; wr_data = '0; mem_ack = 1'b0; mem_rdata = '0;
      step();
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_mem_addr", mem_addr, 64'd0);
      check("rst_beat_idx", 64'(beat_idx), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_rd_last", 64'(rd_last), 64'd0);
      check("rst_rsp_src", 64'(rsp_src), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_wr_data_ack", 64'(wr_data_ack), 64'd0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 5; i++) run_burst(vecs[i]);

      // Request while busy: a pulse is ignored, a held request is taken in cycle N+10.
      req_valid = 1'b1; req_addr = 64'hABCD; req_src = 1'b1; req_write = 1'b0; mem_ack = 1'b1;
      step();
      req_valid = 1'b0;
      finish_burst(1'b0, 1'b1, 64'hABC0, 0, 1'b1);
      step();
      req_valid = 1'b0;
      finish_burst(1'b1, 1'b0, 64'h5640, 0, 1'b0);

      // Reset after three acked read beats.
      req_valid = 1'b1; req_addr = 64'h3000; req_src = 1'b1; req_write = 1'b0;
      step();
      req_valid = 1'b0;
      burst_no++;
      for (int b = 0; b < 3; b++) begin
         mem_ack   = 1'b1;
         mem_rdata = {16'hBEEF, 16'(burst_no), 32'(b)};
         #1;
         check("pre_rst_beat_idx", 64'(beat_idx), 64'(b));
         rd_q.push_back('{data: mem_rdata, last: 1'b0});
         step();
      end
      mem_ack = 1'b0;
      reset   = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check("midrst_mem_req", 64'(mem_req), 64'd0);
      check("midrst_beat_idx", 64'(beat_idx), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_rd_valid", 64'(rd_valid), 64'd0);
      check("midrst_rsp_src", 64'(rsp_src), 64'd0);
      check("midrst_mem_addr", mem_addr, 64'd0);
      check("midrst_req_ready", 64'(req_ready), 64'd1);
      step();
      #1;
      check("midrst_no_done", 64'(done), 64'd0);
      run_burst('{64'h3008, 1'b0, 1'b1, 64'h3000, 0});

      // Spurious ack while idle.
      mem_ack   = 1'b1;
      mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("spur_mem_req", 64'(mem_req), 64'd0);
         check("spur_req_ready", 64'(req_ready), 64'd1);
         check("spur_beat_idx", 64'(beat_idx), 64'd0);
         check("spur_rd_valid", 64'(rd_valid), 64'd0);
         check("spur_done", 64'(done), 64'd0);
         step();
      end
      mem_ack = 1'b0;

      // Stalled read after two beats.
      req_valid = 1'b1; req_addr = 64'h8000; req_src = 1'b0; req_write = 1'b0;
      step();
      req_valid = 1'b0;
      burst_no++;
      for (int b = 0; b < 2; b++) begin
         mem_ack   = 1'b1;
         mem_rdata = {16'hBEEF, 16'(burst_no), 32'(b)};
         rd_q.push_back('{data: mem_rdata, last: 1'b0});
         step();
      end
      mem_ack = 1'b0;
`ifdef MEM_TIMEOUT_EN
      for (int s = 0; s < TIMEOUT; s++) begin
         #1;
         check("to_mem_req_held", 64'(mem_req), 64'd1);
         check("to_no_done_yet", 64'(done), 64'd0);
         step();
      end
      #1;
      check("to_mem_req_drop", 64'(mem_req), 64'd0);
      check("to_done", 64'(done), 64'd1);
      check("to_error", 64'(error), 64'd1);
      check("to_rd_last", 64'(rd_last), 64'd0);
      step();
      #1;
      check("to_req_ready", 64'(req_ready), 64'd1);
      check("to_error_cleared", 64'(error), 64'd0);
`else
      for (int s = 0; s < 1000; s++) begin
         #1;
         check("stall_mem_req", 64'(mem_req), 64'd1);
         check("stall_no_done", 64'(done), 64'd0);
         step();
      end
      check("stall_beat_idx", 64'(beat_idx), 64'd2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check("stall_rst_mem_req", 64'(mem_req), 64'd0);
`endif
      step();
      check("scoreboard_empty", 64'(rd_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Cache-line burst sequencer between the bus arbiter and the memory controller. Once the arbiter has granted the bus to the instruction or data cache, that cache issues one line request here. This block then splits the request into BEATS word transfers over a req/ack memory handshake. It streams read beats back to the requester, fetches write beats from it, and signals completion.

## Interface
Parameters:
- ADDR_W, 64, byte-address width.
- DATA_W, 64, data word width; DATA_W/8 is a power of two.
- BEATS, 8, words per cache line; power of two, ≥2.
- TIMEOUT, 256, per-beat ack wait limit in cycles; only used with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  line request present.
- req_ready  out  1  block can accept a request (IDLE only).
- req_write  in  1  1 = line write-back, 0 = line fill.
- req_src  in  1  requester tag, 0 = I-cache, 1 = D-cache.
- req_addr  in  ADDR_W  line address; low log2(BEATS*DATA_W/8) bits ignored.
- beat_idx  out  log2(BEATS)  index of the current beat.
- wr_data  in  DATA_W  write beat for beat_idx, driven by the requester.
- wr_data_ack  out  1  write beat consumed this cycle.
- rd_data  out  DATA_W  read beat.
- rd_valid  out  1  rd_data valid (one-cycle pulse per beat).
- rd_last  out  1  qualifies the final rd_valid of a line.
- rsp_src  out  1  latched req_src for the active transaction.
- done  out  1  one-cycle pulse at transaction end.
- error  out  1  qualifies done; transaction aborted.
- mem_req  out  1  memory beat request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  beat byte address.
- mem_wdata  out  DATA_W  write data (combinational from wr_data).
- mem_ack  in  1  memory accepted/returned the current beat.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE:**
  - req_ready=1.
  - On req_valid, the block latches the aligned base address, req_write and req_src, and clears beat_idx.
  - Next state is WRITE if req_write, otherwise READ.
- **READ/WRITE:**
  - mem_req=1, mem_we=(state==WRITE).
  - mem_addr = base + beat_idx*(DATA_W/8).
- **On mem_ack:**
  - beat_idx increments.
  - READ: rd_data<=mem_rdata and rd_valid<=1 at the next edge; rd_last<=1 if beat_idx==BEATS-1.
  - WRITE: wr_data_ack=1 combinationally in the ack cycle.
  - Ack on beat BEATS-1 moves the state to DONE; beat_idx wraps to 0.
- **DONE:** done=1 for one cycle, error as recorded, then IDLE.
- mem_req stays high between beats; back-to-back acks are legal, one beat per cycle.
- mem_ack while mem_req=0 is ignored.
- req_valid outside IDLE is ignored; req_ready=0 there.
- rsp_src holds its latched value until the next acceptance.

## Timing
- Reset values: req_ready=1, mem_req=0, mem_we=0, mem_addr=0, beat_idx=0, rd_valid=0, rd_last=0, rsp_src=0, done=0, error=0, wr_data_ack=0.
- Reset mid-transaction: all outputs reach their reset values at the next edge. The partial line is discarded and no done pulse is generated.
- Acceptance at edge N makes mem_req=1 from cycle N+1.
- With mem_ack tied high, beats are acked in cycles N+1..N+BEATS and done is high in cycle N+BEATS+1. req_ready returns in cycle N+BEATS+2, so a new request is accepted there at the earliest.
- READ: rd_valid for beat k appears one cycle after its ack. The last rd_valid coincides with done.
- WRITE: the requester must present wr_data for beat_idx in every cycle mem_req is high.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A per-beat counter clears on acceptance and on each ack, and increments while mem_req=1 and mem_ack=0.
  - When the counter reaches TIMEOUT-1 without an ack, the next state is DONE with error=1. mem_req drops and no further beats are issued.
  - Read beats already delivered remain valid, and rd_last is not asserted.
- MEM_TIMEOUT_EN undefined: the block waits indefinitely for mem_ack, there is no counter, and error is tied 0.

## Test plan
- Read fill: req_addr=0x1234, req_src=1, BEATS=8, mem_ack always 1, mem_rdata=beat index → mem_addr 0x1200,0x1208…0x1238. rd_data 0..7 arrive on consecutive cycles, rd_last only with 7, done in cycle N+9, rsp_src=1, error=0.
- Write-back with stalls: req_write=1, mem_ack high every third cycle → mem_we=1 throughout, one wr_data_ack per ack (8 total), mem_wdata tracks wr_data[beat_idx], done after the 8th ack.
- Request while busy: req_valid pulsed during READ → ignored, req_ready=0; a second request held asserted is accepted in cycle N+10 with ack-always.
- Reset mid-burst: reset asserted after 3 acks → next cycle mem_req=0, beat_idx=0, no done; a following request restarts from beat 0.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT=16): ack beats 0-1, then hold mem_ack=0 → mem_req drops after 16 stall cycles, done=1 with error=1, rd_last never asserted. Without the macro, the block stays in READ with mem_req=1 for 1000 cycles.
- Spurious ack: mem_ack=1 in IDLE → no state change, no rd_valid.
